zone_stream_ctrl: RTL and testbench
===================================

Name: zone_stream_ctrl

Overview:
- Sequencer between the zone-averaging datapath and the WS2812 LED serializer.
- On each frame-complete trigger from the averager, it steps the averager through all zones with `nxt` pulses and captures each averaged colour into a local zone buffer.
- It then streams the buffer to the LED driver over a valid/ready handshake. Streaming starts at a configurable physical zone and runs in a configurable direction, with wrap-around.
- After the last LED it enforces a strip latch/reset gap before accepting the next frame.

Parameters:
- NUM_ZONES, 30, number of perimeter zones/LEDs (2..255).
- RD_LAT, 2, cycles from `nxt` pulse to valid `avg_rgb` (1..15).
- START_OFFSET, 0, buffer index sent as the first LED (0..NUM_ZONES-1).
- REVERSE, 0, 0 = stream with ascending index, 1 = descending index.
- GRB_OUT, 1, 1 = reorder {R,G,B} to {G,R,B} on `led_data`; 0 = pass through.
- RESET_CYC, 8000, idle cycles after the last LED (covers WS2812 >50 us latch).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  averager frame-complete pulse, one cycle.
- avg_rgb  in  24  averaged colour {R[23:16],G[15:8],B[7:0]} from the averager.
- nxt  out  1  one-cycle request to the averager for the next zone.
- led_data  out  24  colour to the LED serializer.
- led_valid  out  1  `led_data` is valid.
- led_ready  in  1  serializer accepts `led_data`.
- zone_idx  out  8  current buffer index (fill pointer or read pointer).
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky: `trig` arrived while busy.

Behaviour:
- Reset: state IDLE; `nxt`, `led_valid`, `busy`, `overrun` = 0; `led_data` = 0; `zone_idx` = 0; counters = 0. Buffer contents are not cleared.
- Reset mid-operation aborts any fill or stream immediately. The next cycle is IDLE with all outputs at reset values.
- IDLE: on `trig` = 1, set fill index to 0 and go to REQ.
- REQ:
  - Assert `nxt` for exactly one cycle.
  - Load the latency counter with RD_LAT.
  - Go to WAIT.
- WAIT:
  - Decrement the counter.
  - When it reaches 0, write `avg_rgb` to `buf[fill]` in that cycle (sample is exactly RD_LAT cycles after the `nxt` cycle).
  - If `fill` == NUM_ZONES-1: set read pointer to START_OFFSET, set LED count to 0, go to STREAM.
  - Otherwise increment `fill` and go to REQ.
- STREAM:
  - Present `buf[rd]` on `led_data`, reordered per GRB_OUT, with `led_valid` = 1.
  - A buffer read stage is allowed, but `led_valid` stays 0 until data is correct.
  - `led_data` must stay stable while `led_valid` = 1 and `led_ready` = 0.
  - On `led_valid` & `led_ready`, advance the pointer:
    - REVERSE = 0: `rd` = (`rd` == NUM_ZONES-1) ? 0 : `rd`+1.
    - REVERSE = 1: `rd` = (`rd` == 0) ? NUM_ZONES-1 : `rd`-1.
  - Increment the LED count. After NUM_ZONES handshakes, drop `led_valid` and go to GAP.
- GAP: count RESET_CYC cycles with `led_valid` = 0, then go to IDLE.
- `zone_idx` shows `fill` in REQ/WAIT, `rd` in STREAM, and 0 otherwise.
- `trig` while not in IDLE (including the final GAP cycle) is ignored and sets `overrun` = 1. Only `rst` clears `overrun`.
- Back-to-back `nxt` pulses are spaced at least RD_LAT+1 cycles apart. There is never more than one outstanding request.
- `led_ready` held low indefinitely stalls STREAM with no data loss. `nxt` is not issued during a stall.
- Datapath is pure routing; no colour arithmetic. Pointer widths are 8 bits and the comparisons above are exact.

Test Plan:
- NUM_ZONES=4, RD_LAT=2, START_OFFSET=0, REVERSE=0, GRB_OUT=0; drive `avg_rgb` = 0x110000, 0x220000, 0x330000, 0x440000 RD_LAT cycles after each `nxt`; `trig` once, `led_ready` tied 1 -> exactly 4 `nxt` pulses spaced 3 cycles apart; `led_data` sequence 0x110000, 0x220000, 0x330000, 0x440000; `led_valid` low for RESET_CYC=5 cycles; then `busy` = 0.
- Same fill, START_OFFSET=2, REVERSE=1 -> output order 0x330000, 0x220000, 0x110000, 0x440000 (wrap 0->3).
- GRB_OUT=1, `avg_rgb` = 0xAABBCC -> `led_data` = 0xBBAACC.
- `led_ready` low for 10 cycles on the 2nd LED -> `led_data` stable and `led_valid` high throughout; no LED lost or duplicated; total handshakes = 4.
- `trig` pulsed during STREAM and again during GAP -> no extra `nxt` pulses, `overrun` = 1 and stays 1 after returning to IDLE; next `trig` starts a normal frame.
- `rst` asserted for 1 cycle in the middle of WAIT of zone 2 -> next cycle `nxt` = 0, `led_valid` = 0, `busy` = 0, `overrun` = 0; a fresh `trig` produces a full 4-zone fill starting at `zone_idx` 0.

Source files
------------

// File: rtl/zone_stream_ctrl_if.sv
// LED stream handshake between zone_stream_ctrl (master) and the WS2812 serializer (slave).
interface zone_stream_ctrl_if;
  logic [23:0] led_data;
  logic        led_valid;
  logic        led_ready;

  modport master (output led_data, output led_valid, input led_ready);
  modport slave  (input led_data, input led_valid, output led_ready);
endinterface

// File: rtl/zone_stream_ctrl.sv
// Frame sequencer: fills the zone buffer from the averager via nxt requests, then
// streams the buffer to the LED serializer with wrap-around and a latch gap.
module zone_stream_ctrl #(
  parameter int unsigned NUM_ZONES    = 30,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned START_OFFSET = 0,
  parameter int unsigned REVERSE      = 0,
  parameter int unsigned GRB_OUT      = 1,
  parameter int unsigned RESET_CYC    = 8000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig,
  input  logic [23:0]         avg_rgb,
  output logic                nxt,
  zone_stream_ctrl_if.master  led,
  output logic [7:0]          zone_idx,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned IW = $clog2(NUM_ZONES);
  localparam int unsigned GW = $clog2(RESET_CYC + 1);
  localparam logic [7:0]  LAST  = 8'(NUM_ZONES - 1);
  localparam logic [7:0]  START = 8'(START_OFFSET);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STREAM, S_GAP} state_t;

  state_t          state, state_n;
  logic [7:0]      fill, rd, lcnt;
  logic [3:0]      lat;
  logic [GW-1:0]   gcnt;
  logic [23:0]     zbuf [NUM_ZONES];
  logic [23:0]     rd_word;
  logic            sample;
  logic            hs;

  // The averaged colour is valid in the cycle the latency counter runs out.
  assign sample  = (state == S_WAIT) && (lat == 4'd1);
  assign hs      = (state == S_STREAM) && led.led_ready;
  assign rd_word = zbuf[IW'(rd)];

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (trig) state_n = S_REQ;
      S_REQ:    state_n = S_WAIT;
      S_WAIT:   if (sample) state_n = (fill == LAST) ? S_STREAM : S_REQ;
      S_STREAM: if (hs && (lcnt == LAST)) state_n = S_GAP;
      S_GAP:    if (gcnt == GW'(RESET_CYC - 1)) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    nxt           = (state == S_REQ);
    busy          = (state != S_IDLE);
    led.led_valid = (state == S_STREAM);
    led.led_data  = '0;
    zone_idx      = '0;
    if (state == S_STREAM) begin
      led.led_data = (GRB_OUT != 0) ? {rd_word[15:8], rd_word[23:16], rd_word[7:0]} : rd_word;
      zone_idx     = rd;
    end else if ((state == S_REQ) || (state == S_WAIT)) begin
      zone_idx = fill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      fill  <= '0;
      rd    <= '0;
      lcnt  <= '0;
      lat   <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: if (trig) fill <= '0;
        S_REQ:  lat <= 4'(RD_LAT);
        S_WAIT: begin
          lat <= lat - 4'd1;
          if (sample) begin
            if (fill == LAST) begin
              rd   <= START;
              lcnt <= '0;
            end else begin
              fill <= fill + 8'd1;
            end
          end
        end
        S_STREAM: begin
          if (hs) begin
            if (REVERSE != 0) rd <= (rd == 8'd0) ? LAST : rd - 8'd1;
            else              rd <= (rd == LAST) ? 8'd0 : rd + 8'd1;
            lcnt <= lcnt + 8'd1;
            gcnt <= '0;
          end
        end
        S_GAP:   gcnt <= gcnt + GW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overrun <= 1'b0;
    else if (trig && (state != S_IDLE)) overrun <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && sample) zbuf[IW'(fill)] <= avg_rgb;
  end

endmodule

// File: tb/tb_zone_stream_ctrl.sv
// Self-checking bench for zone_stream_ctrl: three configurations share one averager model.
module tb_zone_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, trig, rdy;
  logic [23:0] avg_rgb = 24'hE1E1E1;
  logic        nxt0, nxt1, nxt2, busy0, busy1, busy2, ovr0, ovr1, ovr2;
  logic [7:0]  zi0, zi1, zi2;

  zone_stream_ctrl_if lif0 ();
  zone_stream_ctrl_if lif1 ();
  zone_stream_ctrl_if lif2 ();
  assign lif0.led_ready = rdy;
  assign lif1.led_ready = rdy;
  assign lif2.led_ready = rdy;

  always #5 clk = ~clk;

  zone_stream_ctrl #(.NUM_ZONES(4), .RD_LAT(2), .START_OFFSET(0), .REVERSE(0), .GRB_OUT(0), .RESET_CYC(5))
    dut0 (.clk(clk), .rst(rst), .trig(trig), .avg_rgb(avg_rgb), .nxt(nxt0), .led(lif0),
          .zone_idx(zi0), .busy(busy0), .overrun(ovr0));
  zone_stream_ctrl #(.NUM_ZONES(4), .RD_LAT(2), .START_OFFSET(2), .REVERSE(1), .GRB_OUT(0), .RESET_CYC(5))
    dut1 (.clk(clk), .rst(rst), .trig(trig), .avg_rgb(avg_rgb), .nxt(nxt1), .led(lif1),
          .zone_idx(zi1), .busy(busy1), .overrun(ovr1));
  zone_stream_ctrl #(.NUM_ZONES(4), .RD_LAT(2), .START_OFFSET(0), .REVERSE(0), .GRB_OUT(1), .RESET_CYC(5))
    dut2 (.clk(clk), .rst(rst), .trig(trig), .avg_rgb(avg_rgb), .nxt(nxt2), .led(lif2),
          .zone_idx(zi2), .busy(busy2), .overrun(ovr2));

  typedef struct packed {
    logic [0:3][23:0] zin;
    logic [0:3][23:0] e0;
    logic [0:3][23:0] e1;
    logic [0:3][23:0] e2;
  } vec_t;

  vec_t             vecs [2];
  logic [0:3][23:0] ztab;
  int               checks = 0, failures = 0;
  int               cyc = 0, ncnt = 0, lh0 = 0, idle_cyc = 0;
  int               stall_cyc = 0, stall_viol = 0;
  logic             p0 = 0, p1 = 0, p2 = 0;
  logic [23:0]      q0 [$], q1 [$], q2 [$];
  int               nxt_cyc [$];
  logic [7:0]       nxt_zi [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Averager model (RD_LAT=2) plus output monitor, both sampled on the falling edge.
  initial begin
    logic        pv, pr, pb;
    logic [23:0] pd;
    pv = 0; pr = 0; pb = 0; pd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        p0 = 0; p1 = 0; p2 = 0; ncnt = 0;
      end else begin
        p2 = p1; p1 = p0; p0 = nxt0;
        if (nxt0) ncnt++;
      end
      avg_rgb = p2 ? ztab[2'(ncnt - 1)] : 24'hE1E1E1;
      if (nxt0) begin
        nxt_cyc.push_back(cyc);
        nxt_zi.push_back(zi0);
      end
      if (lif0.led_valid && lif0.led_ready) begin
        q0.push_back(lif0.led_data);
        lh0 = cyc;
      end
      if (lif1.led_valid && lif1.led_ready) q1.push_back(lif1.led_data);
      if (lif2.led_valid && lif2.led_ready) q2.push_back(lif2.led_data);
      if (lif0.led_valid && !lif0.led_ready) stall_cyc++;
      if (pv && !pr && (!lif0.led_valid || lif0.led_data != pd)) stall_viol++;
      if (pb && !busy0) idle_cyc = cyc;
      pv = lif0.led_valid; pr = lif0.led_ready; pd = lif0.led_data; pb = busy0;
    end
  end

  task automatic clear_recs();
    q0.delete(); q1.delete(); q2.delete();
    nxt_cyc.delete(); nxt_zi.delete();
    stall_cyc = 0; stall_viol = 0;
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy0}, 32'd0);
  endtask

  task automatic wait_q0(input int want);
    int n = 0;
    while (q0.size() < want && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("q0_wait_timeout", (q0.size() >= want) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_frame(input int v);
    check("q0_size", q0.size(), 4);
    check("q1_size", q1.size(), 4);
    check("q2_size", q2.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("v%0d_led0_%0d", v, i), {8'd0, (i < q0.size()) ? q0[i] : 24'hx}, {8'd0, vecs[v].e0[i]});
      check($sformatf("v%0d_led1_%0d", v, i), {8'd0, (i < q1.size()) ? q1[i] : 24'hx}, {8'd0, vecs[v].e1[i]});
      check($sformatf("v%0d_led2_%0d", v, i), {8'd0, (i < q2.size()) ? q2[i] : 24'hx}, {8'd0, vecs[v].e2[i]});
    end
  endtask

  initial begin
    vecs[0].zin = {24'h110000, 24'h220000, 24'h330000, 24'h440000};
    vecs[0].e0  = {24'h110000, 24'h220000, 24'h330000, 24'h440000};
    vecs[0].e1  = {24'h330000, 24'h220000, 24'h110000, 24'h440000};
    vecs[0].e2  = {24'h001100, 24'h002200, 24'h003300, 24'h004400};
    vecs[1].zin = {24'hAABBCC, 24'h123456, 24'hFF8000, 24'h0102FE};
    vecs[1].e0  = {24'hAABBCC, 24'h123456, 24'hFF8000, 24'h0102FE};
    vecs[1].e1  = {24'hFF8000, 24'h123456, 24'hAABBCC, 24'h0102FE};
    vecs[1].e2  = {24'hBBAACC, 24'h341256, 24'h80FF00, 24'h0201FE};
    ztab = vecs[0].zin;

    rst = 1'b1; trig = 1'b0; rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_nxt", {31'd0, nxt0}, 0);
    check("rst_valid", {31'd0, lif0.led_valid}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_overrun", {31'd0, ovr0}, 0);
    check("rst_zone_idx", {24'd0, zi0}, 0);
    check("rst_led_data", {8'd0, lif0.led_data}, 0);

    // Plain frames, ready tied high.
    for (int v = 0; v < 2; v++) begin
      ztab = vecs[v].zin;
      clear_recs();
      pulse_trig();
      wait_idle();
      check_frame(v);
      check("nxt_count", nxt_cyc.size(), 4);
      for (int i = 1; i < 4; i++)
        check($sformatf("nxt_spacing_%0d", i), (i < nxt_cyc.size()) ? nxt_cyc[i] - nxt_cyc[i-1] : -1, 3);
      for (int i = 0; i < 4; i++)
        check($sformatf("nxt_zone_idx_%0d", i), (i < nxt_zi.size()) ? {24'd0, nxt_zi[i]} : -1, i);
      check("gap_len", idle_cyc - lh0, 6);
      check("overrun_clean", {31'd0, ovr0}, 0);
    end

    // Stall on the second LED for 10 cycles.
    ztab = vecs[0].zin;
    clear_recs();
    pulse_trig();
    wait_q0(1);
    @(posedge clk); #1 rdy = 1'b0;
    repeat (10) @(posedge clk);
    #1 rdy = 1'b1;
    wait_idle();
    check_frame(0);
    check("stall_cycles", stall_cyc, 10);
    check("stall_stability", stall_viol, 0);
    check("stall_nxt_count", nxt_cyc.size(), 4);

    // trig during STREAM and on the final GAP cycle.
    ztab = vecs[1].zin;
    clear_recs();
    pulse_trig();
    wait_q0(1);
    pulse_trig();
    wait_q0(4);
    repeat (4) @(posedge clk);
    pulse_trig();
    wait_idle();
    check("ovr_q0_size", q0.size(), 4);
    check("ovr_flag0", {31'd0, ovr0}, 1);
    check("ovr_flag1", {31'd0, ovr1}, 1);
    repeat (5) @(negedge clk);
    check("ovr_sticky", {31'd0, ovr0}, 1);
    check("ovr_no_extra_nxt", nxt_cyc.size(), 4);
    check("ovr_idle", {31'd0, busy0}, 0);
    clear_recs();
    pulse_trig();
    wait_idle();
    check_frame(1);
    check("after_ovr_nxt_count", nxt_cyc.size(), 4);

    // Reset in the middle of WAIT for zone 2.
    ztab = vecs[0].zin;
    clear_recs();
    pulse_trig();
    begin
      int n = 0;
      while (!(busy0 && zi0 == 8'd2 && !nxt0) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("wait_zone2_timeout", (n < 1000) ? 32'd1 : 32'd0, 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_nxt", {31'd0, nxt0}, 0);
    check("mid_rst_valid", {31'd0, lif0.led_valid}, 0);
    check("mid_rst_busy", {31'd0, busy0}, 0);
    check("mid_rst_overrun", {31'd0, ovr0}, 0);
    check("mid_rst_zone_idx", {24'd0, zi0}, 0);
    clear_recs();
    pulse_trig();
    wait_idle();
    check_frame(0);
    check("post_rst_nxt_count", nxt_cyc.size(), 4);
    check("post_rst_first_idx", (nxt_zi.size() > 0) ? {24'd0, nxt_zi[0]} : -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
